// File: rtl/axi_line_master_pkg.sv
// Shared AXI burst constants, FSM state encoding and line/beat types for the core's AXI blocks.
package axi_line_master_pkg;

  localparam int unsigned BEAT_W     = 32;
  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned LINE_W     = BEAT_W * LINE_BEATS;
  localparam int unsigned BEAT_IDX_W = 2;

  localparam logic [3:0] LEN_LINE   = 4'd3;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] STRB_FULL  = 4'hF;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_RESP = 3'd6
  } line_state_e;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [LINE_W-1:0] line_t;

  // Beat index that follows idx within a line (wraps 3 -> 0).
  function automatic logic [BEAT_IDX_W-1:0] next_beat(input logic [BEAT_IDX_W-1:0] idx);
    return idx + BEAT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/axi_line_master_line_beat_buf.sv
// 4x32 line buffer: whole-line load, single-beat write, beat read mux and flat line view.
module line_beat_buf
  import axi_line_master_pkg::*;
(
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  load_en,
  input  logic [LINE_W-1:0]     load_line,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_idx,
  input  logic [BEAT_W-1:0]     wr_data,
  input  logic [BEAT_IDX_W-1:0] rd_idx,
  output logic [BEAT_W-1:0]     rd_data_c,
  output logic [LINE_W-1:0]     line_data
);

  beat_t slot_q [LINE_BEATS];

  // Storage: a whole-line load takes priority over a single beat write.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      for (int unsigned i = 0; i < LINE_BEATS; i++) begin
        slot_q[i[BEAT_IDX_W-1:0]] <= '0;
      end
    end else if (load_en) begin
      for (int unsigned i = 0; i < LINE_BEATS; i++) begin
        slot_q[i[BEAT_IDX_W-1:0]] <= load_line[i*BEAT_W +: BEAT_W];
      end
    end else if (wr_en) begin
      slot_q[wr_idx] <= wr_data;
    end
  end

  // Beat read mux.
  always_comb begin
    rd_data_c = slot_q[rd_idx];
  end

  // Flat line view, beat 0 in the low word.
  always_comb begin
    line_data = '0;
    for (int unsigned i = 0; i < LINE_BEATS; i++) begin
      line_data[i*BEAT_W +: BEAT_W] = slot_q[i[BEAT_IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/axi_line_master.sv
// Cache line AXI master: one outstanding 4-beat INCR refill or write-back at a time.
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter int unsigned WIDTH_ID = 2,
  parameter int unsigned WIDTH_DA = 32,
  parameter int unsigned WIDTH_AD = 32
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,
  // line request / completion
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WIDTH_AD-1:0] req_addr,
  input  logic [127:0]        req_wline,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [127:0]        resp_rline,
  output logic                resp_err,
  // AW
  output logic [WIDTH_ID-1:0] AWID,
  output logic [WIDTH_AD-1:0] AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  // W
  output logic [WIDTH_DA-1:0] WDATA,
  output logic [3:0]          WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // B
  input  logic [WIDTH_ID-1:0] BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // AR
  output logic [WIDTH_ID-1:0] ARID,
  output logic [WIDTH_AD-1:0] ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  // R
  input  logic [WIDTH_ID-1:0] RID,
  input  logic [WIDTH_DA-1:0] RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  line_state_e           state_q;
  logic [BEAT_IDX_W-1:0] beat_cnt_q;
  logic                  err_q;
  logic [WIDTH_AD-1:0]   addr_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  beat_t                 wdata_q;
  logic                  bready_q;

  logic                  load_en_c;
  logic                  wr_en_c;
  logic [BEAT_IDX_W-1:0] rd_idx_c;
  beat_t                 rd_data_c;
  line_t                 line_data;

  // IDs, ordering and slave IDs are irrelevant with a single outstanding transaction.
  logic unused_inputs;
  assign unused_inputs = ^{BID, RID, req_addr[3:0]};

  // Buffer port control: load on acceptance, write on R beats, prefetch the next W beat.
  always_comb begin
    load_en_c = req_valid && req_ready_q;
    wr_en_c   = (state_q == ST_R) && RVALID && rready_q;
    rd_idx_c  = (state_q == ST_W) ? next_beat(beat_cnt_q) : '0;
  end

  line_beat_buf u_buf (
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARESETN (M_AXI_ARESETN),
    .load_en       (load_en_c),
    .load_line     (req_wline),
    .wr_en         (wr_en_c),
    .wr_idx        (beat_cnt_q),
    .wr_data       (BEAT_W'(RDATA)),
    .rd_idx        (rd_idx_c),
    .rd_data_c     (rd_data_c),
    .line_data     (line_data)
  );

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= {req_addr[WIDTH_AD-1:4], 4'h0};
            req_ready_q <= 1'b0;
            if (req_we) begin
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end

        ST_R: begin
          if (RVALID) begin
            beat_cnt_q <= next_beat(beat_cnt_q);
            if ((RRESP != RESP_OKAY) || (RLAST != (beat_cnt_q == LAST_BEAT))) begin
              err_q <= 1'b1;
            end
            if (beat_cnt_q == LAST_BEAT) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end

        ST_AW: begin
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= rd_data_c;
            wlast_q   <= (LAST_BEAT == '0);
            state_q   <= ST_W;
          end
        end

        ST_W: begin
          if (WREADY) begin
            beat_cnt_q <= next_beat(beat_cnt_q);
            if (beat_cnt_q == LAST_BEAT) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              wdata_q <= rd_data_c;
              wlast_q <= (next_beat(beat_cnt_q) == LAST_BEAT);
            end
          end
        end

        ST_B: begin
          if (BVALID) begin
            bready_q     <= 1'b0;
            err_q        <= (BRESP != RESP_OKAY);
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping: fixed burst shape, shared line address for both directions.
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rline = line_data;
  assign resp_err   = err_q;

  assign AWID    = '0;
  assign AWADDR  = addr_q;
  assign AWLEN   = LEN_LINE;
  assign AWSIZE  = SIZE_WORD;
  assign AWBURST = BURST_INCR;
  assign AWVALID = awvalid_q;

  assign WDATA  = WIDTH_DA'(wdata_q);
  assign WSTRB  = STRB_FULL;
  assign WLAST  = wlast_q;
  assign WVALID = wvalid_q;

  assign BREADY = bready_q;

  assign ARID    = '0;
  assign ARADDR  = addr_q;
  assign ARLEN   = LEN_LINE;
  assign ARSIZE  = SIZE_WORD;
  assign ARBURST = BURST_INCR;
  assign ARVALID = arvalid_q;

  assign RREADY = rready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// Randomized bench: the bench plays the AXI slave over a word memory model and checks each line transaction.
module tb_axi_line_master;

  localparam int unsigned WIDTH_ID = 2;
  localparam int unsigned WIDTH_DA = 32;
  localparam int unsigned WIDTH_AD = 32;
  localparam int unsigned BOUND    = 200;

  logic M_AXI_ACLK = 1'b0;
  logic M_AXI_ARESETN;
  logic req_valid, req_ready, req_we;
  logic [WIDTH_AD-1:0] req_addr;
  logic [127:0] req_wline, resp_rline;
  logic resp_valid, resp_ready, resp_err;
  logic [WIDTH_ID-1:0] AWID, ARID, BID, RID;
  logic [WIDTH_AD-1:0] AWADDR, ARADDR;
  logic [3:0] AWLEN, ARLEN, WSTRB;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [WIDTH_DA-1:0] WDATA, RDATA;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [int unsigned];

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  axi_line_master #(.WIDTH_ID(WIDTH_ID), .WIDTH_DA(WIDTH_DA), .WIDTH_AD(WIDTH_AD)) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wline(req_wline), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rline(resp_rline), .resp_err(resp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge M_AXI_ACLK);
    #1;
  endtask

  // Slave memory: unwritten words read back as an address-derived pattern.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic int rnd_wait(input bit zw);
    return zw ? 0 : int'($urandom_range(0, 3));
  endfunction

  task automatic slave_idle();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_arvalid"}, ARVALID, 1'b0);
    check_eq({tag, "_awvalid"}, AWVALID, 1'b0);
    check_eq({tag, "_wvalid"}, WVALID, 1'b0);
    check_eq({tag, "_rready"}, RREADY, 1'b0);
    check_eq({tag, "_bready"}, BREADY, 1'b0);
    check_eq({tag, "_resp_valid"}, resp_valid, 1'b0);
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    check_eq({tag, "_resp_err"}, resp_err, 1'b0);
    check_eq({tag, "_resp_rline"}, resp_rline, 128'h0);
  endtask

  task automatic do_reset();
    slave_idle();
    req_valid = 1'b0; resp_ready = 1'b0;
    M_AXI_ARESETN = 1'b0;
    tick(); tick();
    M_AXI_ARESETN = 1'b1;
  endtask

  // Completion phase: hold resp_ready low for 'hold' cycles, then handshake.
  task automatic wait_resp(input logic [127:0] exp_line, input bit exp_err, input int hold);
    bit seen = 0;
    for (int t = 0; t < BOUND && !seen; t++) begin
      if (resp_valid) seen = 1;
      else tick();
    end
    if (!seen) begin
      check_eq("resp_timeout", 1'b0, 1'b1);
      do_reset();
      return;
    end
    resp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check_eq("resp_hold_valid", resp_valid, 1'b1);
      check_eq("resp_hold_line", resp_rline, exp_line);
      check_eq("resp_hold_req_ready", req_ready, 1'b0);
      tick();
    end
    check_eq("resp_valid", resp_valid, 1'b1);
    check_eq("resp_rline", resp_rline, exp_line);
    check_eq("resp_err", resp_err, exp_err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("resp_done_valid", resp_valid, 1'b0);
    check_eq("resp_done_req_ready", req_ready, 1'b1);
  endtask

  // Line refill; rlast_bad / rresp_bad name a beat to corrupt (-1 = none).
  task automatic do_refill(input logic [31:0] addr, input bit zw, input int gap_after,
                           input int gap_len, input int hold, input int rlast_bad,
                           input int rresp_bad, input logic [1:0] bad_resp, input bit chk_lat);
    logic [31:0]  base;
    logic [127:0] exp_line;
    bit exp_err, ok, hs;
    int waits, i, gap, cyc;
    base = {addr[31:4], 4'h0};
    for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = rd_word(base + 32'(4*k));
    exp_err = (rlast_bad >= 0) || (rresp_bad >= 0 && bad_resp != 2'b00);
    check_eq("ref_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    req_wline = {$urandom, $urandom, $urandom, $urandom};
    tick();
    req_valid = 1'b0; cyc = 0;
    waits = rnd_wait(zw); ok = 0;
    for (int t = 0; t < BOUND && !ok; t++) begin
      check_eq("ar_valid", ARVALID, 1'b1);
      check_eq("ar_addr", ARADDR, base);
      check_eq("ar_req_ready", req_ready, 1'b0);
      check_eq("ar_rready", RREADY, 1'b0);
      RVALID = zw ? 1'b0 : 1'($urandom_range(0, 1));
      RDATA = $urandom; RLAST = 1'b1;
      ARREADY = (t >= waits);
      if (ARREADY) begin
        check_eq("ar_len", ARLEN, 4'd3);
        check_eq("ar_size", ARSIZE, 3'd2);
        check_eq("ar_burst", ARBURST, 2'b01);
        check_eq("ar_id", ARID, 2'd0);
      end
      ok = ARREADY && ARVALID;
      tick(); cyc++;
    end
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    if (!ok) begin check_eq("ar_timeout", 1'b0, 1'b1); do_reset(); return; end
    i = 0; gap = 0;
    for (int t = 0; t < BOUND && i < 4; t++) begin
      check_eq("r_rready", RREADY, 1'b1);
      check_eq("r_req_ready", req_ready, 1'b0);
      if (gap > 0) begin
        RVALID = 1'b0; gap--;
      end else if (!zw && $urandom_range(0, 3) == 0) begin
        RVALID = 1'b0;
      end else begin
        RVALID = 1'b1;
        RDATA = exp_line[i*32 +: 32];
        RRESP = (i == rresp_bad) ? bad_resp : 2'b00;
        RLAST = (i == 3) ^ (i == rlast_bad);
      end
      hs = RVALID && RREADY;
      tick(); cyc++;
      if (hs) begin
        if (i == gap_after) gap = gap_len;
        i++;
      end
    end
    RRESP = 2'b00; RLAST = 1'b0;
    if (i < 4) begin RVALID = 1'b0; check_eq("r_timeout", 1'b0, 1'b1); do_reset(); return; end
    RVALID = 1'b1; RDATA = 32'hBAD0_BAD0;
    check_eq("r_no_fifth_beat", RREADY, 1'b0);
    if (chk_lat) begin
      check_eq("lat_cycles", 32'(cyc), 32'd5);
      check_eq("lat_resp_valid", resp_valid, 1'b1);
    end
    tick();
    RVALID = 1'b0;
    wait_resp(exp_line, exp_err, hold);
  endtask

  // Line write-back; rst_beat (>=0) pulses reset while that W beat is presented.
  task automatic do_write(input logic [31:0] addr, input logic [127:0] line, input bit zw,
                          input logic [1:0] bresp, input int hold, input int rst_beat);
    logic [31:0] base;
    bit ok, hs;
    int waits, i;
    base = {addr[31:4], 4'h0};
    check_eq("wb_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wline = line;
    tick();
    req_valid = 1'b0; req_wline = {$urandom, $urandom, $urandom, $urandom};
    waits = rnd_wait(zw); ok = 0;
    for (int t = 0; t < BOUND && !ok; t++) begin
      check_eq("aw_valid", AWVALID, 1'b1);
      check_eq("aw_addr", AWADDR, base);
      check_eq("aw_wvalid", WVALID, 1'b0);
      WREADY = zw ? 1'b0 : 1'($urandom_range(0, 1));
      AWREADY = (t >= waits);
      if (AWREADY) begin
        check_eq("aw_len", AWLEN, 4'd3);
        check_eq("aw_size", AWSIZE, 3'd2);
        check_eq("aw_burst", AWBURST, 2'b01);
        check_eq("aw_id", AWID, 2'd0);
      end
      ok = AWREADY && AWVALID;
      tick();
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    if (!ok) begin check_eq("aw_timeout", 1'b0, 1'b1); do_reset(); return; end
    i = 0;
    for (int t = 0; t < BOUND && i < 4; t++) begin
      check_eq("w_valid", WVALID, 1'b1);
      check_eq("w_data", WDATA, line[i*32 +: 32]);
      check_eq("w_last", WLAST, i == 3);
      check_eq("w_strb", WSTRB, 4'hF);
      check_eq("w_bready", BREADY, 1'b0);
      if (i == rst_beat) begin
        WREADY = 1'b0;
        M_AXI_ARESETN = 1'b0;
        tick();
        M_AXI_ARESETN = 1'b1;
        check_quiet("mid_reset");
        return;
      end
      WREADY = zw ? 1'b1 : 1'($urandom_range(0, 1));
      hs = WREADY && WVALID;
      tick();
      if (hs) i++;
    end
    WREADY = 1'b0;
    if (i < 4) begin check_eq("w_timeout", 1'b0, 1'b1); do_reset(); return; end
    check_eq("w_done_wvalid", WVALID, 1'b0);
    waits = zw ? 0 : int'($urandom_range(0, 4)); ok = 0;
    for (int t = 0; t < BOUND && !ok; t++) begin
      check_eq("b_bready", BREADY, 1'b1);
      BVALID = (t >= waits); BRESP = bresp;
      ok = BVALID && BREADY;
      tick();
    end
    BVALID = 1'b0; BRESP = 2'b00;
    if (!ok) begin check_eq("b_timeout", 1'b0, 1'b1); do_reset(); return; end
    for (int k = 0; k < 4; k++) mem[base + 32'(4*k)] = line[k*32 +: 32];
    wait_resp(line, bresp != 2'b00, hold);
  endtask

  initial begin
    logic [127:0] line;
    logic [31:0]  a;
    bit zw;
    int rl, rr;
    logic [1:0] br;
    req_we = 1'b0; req_addr = '0; req_wline = '0;
    do_reset();
    check_quiet("reset");

    // Zero-wait refill with a preloaded line and latency check.
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    do_refill(32'h104, 1, -1, 0, 0, -1, -1, 2'b00, 1);
    check_eq("refill_0x104_line", resp_rline, 128'h00000044_00000033_00000022_00000011);
    check_eq("refill_0x104_araddr", ARADDR, 32'h100);

    // Write-back then read back the same line.
    line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    do_write(32'h200, line, 1, 2'b00, 0, -1);
    check_eq("wb_0x200_awaddr", AWADDR, 32'h200);
    do_refill(32'h200, 1, -1, 0, 0, -1, -1, 2'b00, 0);
    check_eq("readback_0x200", resp_rline, line);

    // RVALID gap between beats 1 and 2, completion held off 5 cycles.
    do_refill(32'h308, 1, 1, 3, 5, -1, -1, 2'b00, 0);

    // Protocol errors: early RLAST on beat 1, SLVERR on beat 2.
    do_refill(32'h400, 1, -1, 0, 0, 1, -1, 2'b00, 0);
    do_refill(32'h410, 1, -1, 0, 0, -1, 2, 2'b10, 0);

    // Reset during W beat 2, then a normal refill.
    do_write(32'h500, {$urandom, $urandom, $urandom, $urandom}, 1, 2'b00, 0, 2);
    do_refill(32'h600, 1, -1, 0, 1, -1, -1, 2'b00, 0);

    // Random mix of refills and write-backs over a small address window.
    for (int n = 0; n < 40; n++) begin
      a  = {20'h0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      zw = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        do_write(a, {$urandom, $urandom, $urandom, $urandom}, zw, br,
                 int'($urandom_range(0, 3)), -1);
      end else begin
        rl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        rr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        do_refill(a, zw, -1, 0, int'($urandom_range(0, 3)), rl, rr,
                  2'($urandom_range(1, 3)), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameter WIDTH_ID, default 2: AXI ID width.
REQ-002 Parameter WIDTH_DA, default 32: AXI data width; only 32 is supported.
REQ-003 Parameter WIDTH_AD, default 32: AXI address width.
REQ-004 M_AXI_ACLK  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 M_AXI_ARESETN  in  1  reset; synchronous, active-low.
REQ-006 req_valid / req_ready  in / out  1 / 1  cache line-request handshake.
REQ-007 req_we  in  1  request type: 1 = line write-back, 0 = line refill.
REQ-008 req_addr  in  WIDTH_AD  line byte address; bits [3:0] ignored.
REQ-009 req_wline  in  128  write-back line data; bits [31:0] = beat 0.
REQ-010 resp_valid / resp_ready  out / in  1 / 1  completion handshake.
REQ-011 resp_rline  out  128  refill data, beat 0 in bits [31:0]; resp_err  out  1  error flag for the transaction.
REQ-012 AW channel, all out except AWREADY (in): AWID[WIDTH_ID], AWADDR[WIDTH_AD], AWLEN[4], AWSIZE[3], AWBURST[2], AWVALID, AWREADY.
REQ-013 W channel, all out except WREADY (in): WDATA[32], WSTRB[4], WLAST, WVALID, WREADY.
REQ-014 B channel: BID[WIDTH_ID] in, BRESP[2] in, BVALID in, BREADY out.
REQ-015 AR channel, all out except ARREADY (in): ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY.
REQ-016 R channel, all in except RREADY (out): RID, RDATA[32], RRESP[2], RLAST, RVALID, RREADY.

Function
REQ-017 The block SHALL have one outstanding transaction at most, and SHALL use FSM states IDLE, AR, R, AW, W, B, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; on req_valid&req_ready the block SHALL register the address (with [3:0] forced to 0), req_we and req_wline, and go to AW if req_we=1, otherwise to AR.
REQ-019 Every burst SHALL drive AxID=0, AxLEN=3, AxSIZE=2, AxBURST=INCR(01), and WSTRB=4'hF.
REQ-020 ARVALID/AWVALID SHALL assert in the cycle after request acceptance and hold stable with address until the corresponding READY is sampled high.
REQ-021 R state: RREADY=1; each RVALID&RREADY SHALL store RDATA into line slot beat_cnt (2-bit counter, 0..3), then increment beat_cnt.
REQ-022 On beat 3 the FSM SHALL go to RESP; resp_err SHALL be set if any beat has RRESP!=00, or if RLAST disagrees with (beat_cnt==3).
REQ-023 W state (entered after AW handshake): WVALID=1, WDATA = line slot beat_cnt, WLAST = (beat_cnt==3); on handshake of beat 3, go to B.
REQ-024 B state: BREADY=1; on BVALID, set resp_err = (BRESP!=00) and go to RESP.
REQ-025 RESP state: resp_valid=1 with resp_rline/resp_err stable until resp_ready; on handshake, clear beat_cnt and err, go to IDLE.
REQ-026 Latency for a refill with zero-wait slave: request accepted at cycle N; AR handshake at N+1; beats at N+2..N+5; resp_valid at N+6.
REQ-027 The block SHALL tolerate RVALID/WREADY gaps between beats and any number of AR/AW/B wait cycles, with no timeout.
REQ-028 Beats on any channel outside its owning state SHALL NOT be consumed (the matching READY is 0).
REQ-029 resp_rline for a write-back SHALL equal the written line.

Reset
REQ-030 When ARESETN=0 is sampled, the FSM SHALL go to IDLE; beat_cnt and resp_err SHALL be 0; all VALID and READY outputs SHALL be 0 except req_ready, which SHALL be 1 after reset release; resp_rline SHALL be 0.
REQ-031 A reset mid-burst SHALL abandon the transaction without completing the remaining AXI beats; the system resets the slave concurrently.

Structure
REQ-032 The AXI constants (LEN_LINE=3, SIZE_WORD=2, BURST_INCR=01, RESP_OKAY=00) and the FSM state encodings SHALL live in a shared include/package used by all AXI blocks of the core.
REQ-033 There SHALL be one sub-module, line_beat_buf: a 4x32 register file with a beat write port, a beat read mux and a 128-bit load/read; the FSM stays in the top level.

Verification
REQ-034 Refill addr 0x0000_0104, zero-wait slave preloaded 0x11,0x22,0x33,0x44 -> ARADDR 0x100, ARLEN 3, resp_rline 0x00000044_00000033_00000022_00000011 at N+6, resp_err 0.
REQ-035 Write-back addr 0x200, line 0xDDDD_CCCC_BBBB_AAAA_... (4 words) -> AWADDR 0x200, WDATA sequence beat0..3, WLAST only on beat 3, BRESP 00 -> resp_err 0; a following refill of 0x200 returns the same line.
REQ-036 Refill with RVALID dropped 3 cycles between beats 1 and 2, resp_ready held low 5 cycles -> data correct, resp_valid held stable 5 cycles, req_ready=0 throughout.
REQ-037 Refill where the slave raises RLAST on beat 1, or returns RRESP=10 on beat 2 -> resp_err=1 and still exactly 4 beats consumed.
REQ-038 ARESETN low for 1 cycle during W beat 2 -> next cycle all VALIDs 0, FSM IDLE, and a new refill completes normally.
